// File: rtl/port_ctrl.sv
// port_ctrl: parametrised GPIO port SFR block.
// Output latch with byte/bit writes, synchronised pin reads, latch reads for
// read-modify-write, and per-pin falling-edge interrupt flags with an enable
// mask and an aggregated interrupt request.

// Per-pin synchroniser plus falling-edge detector.
module port_ctrl_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_pin,
    output logic o_sync,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;

    // Shift the raw pin into the chain; the oldest sample is the clean level.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], i_pin};
    end

    // Chain and previous level reset high so a pin held high never looks
    // like a falling edge once reset is released.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign o_sync = sync_q[SYNC_STAGES-1];
    assign o_fall = prev_q & ~sync_q[SYNC_STAGES-1];

endmodule

module port_ctrl #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VAL   = '0,
    parameter int               SYNC_STAGES = 2,
    localparam int              IDX_W       = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_byte,
    input  logic [IDX_W-1:0] i_bit_idx,
    input  logic             i_bit_val,
    input  logic [WIDTH-1:0] i_pins,
    output logic [WIDTH-1:0] o_latch,
    output logic [WIDTH-1:0] o_rd_data,
    output logic [WIDTH-1:0] o_flags,
    output logic             o_irq
);

    typedef enum logic [2:0] {
        OP_NOP       = 3'd0,
        OP_WR_BYTE   = 3'd1,
        OP_WR_BIT    = 3'd2,
        OP_CPL_BIT   = 3'd3,
        OP_RD_PIN    = 3'd4,
        OP_RD_LATCH  = 3'd5,
        OP_CLR_FLAGS = 3'd6,
        OP_SET_IE    = 3'd7
    } op_e;

    op_e              op;
    logic [WIDTH-1:0] bit_mask;
    logic [WIDTH-1:0] pin_sync;
    logic [WIDTH-1:0] pin_fall;

    logic [WIDTH-1:0] latch_q, latch_d;
    logic [WIDTH-1:0] rd_q,    rd_d;
    logic [WIDTH-1:0] flags_q, flags_d;
    logic [WIDTH-1:0] ie_q,    ie_d;

    assign op = op_e'(i_op);

    // One-hot bit select. An index past the top bit shifts the one out
    // entirely, giving an empty mask, so out-of-range bit ops are no-ops.
    assign bit_mask = {{(WIDTH-1){1'b0}}, 1'b1} << i_bit_idx;

    // One synchroniser/edge detector per pin.
    for (genvar g = 0; g < WIDTH; g++) begin : g_pin
        port_ctrl_pin_sync #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .i_clk (i_clk),
            .i_rst (i_rst),
            .i_pin (i_pins[g]),
            .o_sync(pin_sync[g]),
            .o_fall(pin_fall[g])
        );
    end

    // Output latch next state: byte write, bit write, bit complement.
    always_comb begin
        latch_d = latch_q;
        case (op)
            OP_WR_BYTE: latch_d = i_byte;
            OP_WR_BIT:  latch_d = i_bit_val ? (latch_q | bit_mask)
                                            : (latch_q & ~bit_mask);
            OP_CPL_BIT: latch_d = latch_q ^ bit_mask;
            default:    latch_d = latch_q;
        endcase
    end

    // Read result: captured only by the two read ops, held otherwise.
    // RD_LATCH samples the latch register, i.e. the pre-edge value.
    always_comb begin
        rd_d = rd_q;
        case (op)
            OP_RD_PIN:   rd_d = pin_sync;
            OP_RD_LATCH: rd_d = latch_q;
            default:     rd_d = rd_q;
        endcase
    end

    // Interrupt enable mask.
    always_comb begin
        ie_d = ie_q;
        if (op == OP_SET_IE) ie_d = i_byte;
    end

    // Sticky flags: clear first, then OR in enabled edges so a same-cycle
    // edge beats a clear on the same bit.
    always_comb begin
        flags_d = flags_q;
        if (op == OP_CLR_FLAGS) flags_d = flags_q & ~i_byte;
        flags_d = flags_d | (pin_fall & ie_q);
    end

    // State registers; reset overrides any op presented in the same cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            latch_q <= RESET_VAL;
            rd_q    <= '0;
            flags_q <= '0;
            ie_q    <= '0;
        end else begin
            latch_q <= latch_d;
            rd_q    <= rd_d;
            flags_q <= flags_d;
            ie_q    <= ie_d;
        end
    end

    assign o_latch   = latch_q;
    assign o_rd_data = rd_q;
    assign o_flags   = flags_q;
    assign o_irq     = |flags_q;

endmodule

// File: tb/tb_port_ctrl.sv
// Directed testbench for port_ctrl: an 8-bit instance with RESET_VAL=A5 and
// a 6-bit instance for out-of-range bit index handling.
module tb_port_ctrl;

    localparam logic [2:0] NOP = 3'd0, WR_BYTE = 3'd1, WR_BIT = 3'd2,
                           CPL_BIT = 3'd3, RD_PIN = 3'd4, RD_LATCH = 3'd5,
                           CLR_FLAGS = 3'd6, SET_IE = 3'd7;

    logic       clk;
    logic       rst;

    // 8-bit instance
    logic [2:0] op;
    logic [7:0] byte_v;
    logic [2:0] idx;
    logic       bval;
    logic [7:0] pins;
    logic [7:0] latch, rd, flags;
    logic       irq;

    // 6-bit instance
    logic [2:0] op6;
    logic [5:0] byte6;
    logic [2:0] idx6;
    logic       bval6;
    logic [5:0] pins6;
    logic [5:0] latch6, rd6, flags6;
    logic       irq6;

    int n_run  = 0;
    int n_fail = 0;

    port_ctrl #(.WIDTH(8), .RESET_VAL(8'hA5), .SYNC_STAGES(2)) dut (
        .i_clk(clk), .i_rst(rst), .i_op(op), .i_byte(byte_v),
        .i_bit_idx(idx), .i_bit_val(bval), .i_pins(pins),
        .o_latch(latch), .o_rd_data(rd), .o_flags(flags), .o_irq(irq)
    );

    port_ctrl #(.WIDTH(6), .RESET_VAL(6'h00), .SYNC_STAGES(2)) dut6 (
        .i_clk(clk), .i_rst(rst), .i_op(op6), .i_byte(byte6),
        .i_bit_idx(idx6), .i_bit_val(bval6), .i_pins(pins6),
        .o_latch(latch6), .o_rd_data(rd6), .o_flags(flags6), .o_irq(irq6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_op(input logic [2:0] o, input logic [7:0] b);
        op = o; byte_v = b;
        step();
        op = NOP;
    endtask

    initial begin
        rst = 1'b1; op = NOP; byte_v = '0; idx = '0; bval = 1'b0; pins = 8'hFF;
        op6 = NOP; byte6 = '0; idx6 = '0; bval6 = 1'b0; pins6 = 6'h3F;
        step(3);
        rst = 1'b0;

        // Reset state
        check("rst_latch", latch, 8'hA5);
        check("rst_rd",    rd,    8'h00);
        check("rst_flags", flags, 8'h00);
        check("rst_irq",   irq,   1'b0);
        check("rst_latch6", latch6, 6'h00);

        // Byte write and latch read
        do_op(WR_BYTE, 8'h3C);
        check("wr_byte", latch, 8'h3C);
        do_op(RD_LATCH, 8'h00);
        check("rd_latch", rd, 8'h3C);

        // Bit operations
        idx = 3'd7; bval = 1'b1; do_op(WR_BIT, 8'h00);
        check("wr_bit7", latch, 8'hBC);
        idx = 3'd2; do_op(CPL_BIT, 8'h00);
        check("cpl_bit2", latch, 8'hB8);
        do_op(CPL_BIT, 8'h00);
        check("cpl_bit2_again", latch, 8'hBC);
        check("rd_hold", rd, 8'h3C);

        // 6-bit instance: out-of-range index leaves latch unchanged
        op6 = WR_BYTE; byte6 = 6'h2A; step(); op6 = NOP;
        check("w6_wr_byte", latch6, 6'h2A);
        op6 = WR_BIT; idx6 = 3'd7; bval6 = 1'b1; step(); op6 = NOP;
        check("w6_wr_bit_oob", latch6, 6'h2A);
        op6 = CPL_BIT; idx6 = 3'd6; step(); op6 = NOP;
        check("w6_cpl_oob", latch6, 6'h2A);
        op6 = WR_BIT; idx6 = 3'd5; bval6 = 1'b0; step(); op6 = NOP;
        check("w6_wr_bit5", latch6, 6'h0A);

        // Pin read latency
        pins = 8'hF0;
        step();
        do_op(RD_PIN, 8'h00);
        check("rd_pin_early", rd, 8'hFF);
        step();
        do_op(RD_PIN, 8'h00);
        check("rd_pin_late", rd, 8'hF0);
        check("fall_ie0_flags", flags, 8'h00);
        pins = 8'hFF;
        step(4);
        check("rise_ie0_flags", flags, 8'h00);

        // Enabled falling edge on pin0: flag exactly 3 cycles after change
        do_op(SET_IE, 8'h01);
        pins = 8'hFE;
        step(2);
        check("edge_flag_c2", flags, 8'h00);
        step();
        check("edge_flag_c3", flags, 8'h01);
        check("edge_irq", irq, 1'b1);

        // Pin1 fall with ie[1]=0 is ignored
        pins = 8'hFC;
        step(5);
        check("ie0_pin1", flags, 8'h01);

        // ie=03, raise pins (no flag), then clear collides with a pin0 fall
        do_op(SET_IE, 8'h03);
        pins = 8'hFF;
        step(4);
        check("rise_no_flag", flags, 8'h01);
        pins = 8'hFE;
        step(2);
        do_op(CLR_FLAGS, 8'h01);
        check("clr_vs_set", flags, 8'h01);
        do_op(CLR_FLAGS, 8'h01);
        check("clr_flags", flags, 8'h00);
        check("clr_irq", irq, 1'b0);
        pins = 8'hFF;
        step(5);
        check("pin0_rise", flags, 8'h00);

        // Build flags=03, return pins high, then reset over WR_BYTE
        pins = 8'hFC;
        step(4);
        check("flags_03", flags, 8'h03);
        pins = 8'hFF;
        step(4);
        rst = 1'b1; op = WR_BYTE; byte_v = 8'h55;
        step();
        rst = 1'b0; op = NOP;
        check("rst_mid_latch", latch, 8'hA5);
        check("rst_mid_flags", flags, 8'h00);
        check("rst_mid_rd",    rd,    8'h00);
        check("rst_mid_irq",   irq,   1'b0);
        do_op(SET_IE, 8'h03);
        step(4);
        check("no_spurious_edge", flags, 8'h00);

        // ie is cleared by reset: a fall after reset sets nothing
        rst = 1'b1; step(); rst = 1'b0;
        pins = 8'hFE;
        step(5);
        check("ie_reset", flags, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
